// File: rtl/dl_pkg.sv
// Shared definitions for the delayline frame streamer.
//   - FSM state encodings (spare encoding recovers to idle)
//   - default sync byte
//   - frame_len(): bytes per frame for a given channel geometry
package dl_pkg;

    localparam logic [1:0] StIdle  = 2'b00;
    localparam logic [1:0] StPush  = 2'b01;
    localparam logic [1:0] StSpare = 2'b10;
    localparam logic [1:0] StWait  = 2'b11;

    localparam logic [7:0] SyncByteDefault = 8'hA5;

    // Sync + sequence + payload + checksum.
    function automatic int unsigned frame_len(input int unsigned datasize,
                                              input int unsigned nch);
        return 3 + (nch * datasize) / 8;
    endfunction

endpackage

// File: rtl/dl_frame_streamer_if.sv
// Byte handshake between the frame streamer and an external UART transmitter.
//   tx_byte : byte to transmit, held stable until the UART reports completion
//   tx_push : one-cycle send request
//   tx_done : one-cycle completion pulse from the UART
interface dl_frame_streamer_if;

    logic [7:0] tx_byte;
    logic       tx_push;
    logic       tx_done;

    modport master (output tx_byte, output tx_push, input tx_done);
    modport slave  (input tx_byte, input tx_push, output tx_done);

endinterface

// File: rtl/dl_tick_gen.sv
// Sample tick divider.
//   clk10m       : system clock
//   rst          : synchronous active-high reset
//   clk_sampling : registered one-cycle pulse every SAMPLE_DIV cycles
module dl_tick_gen #(
    parameter int unsigned SAMPLE_DIV = 333333
) (
    input  logic clk10m,
    input  logic rst,
    output logic clk_sampling
);

    localparam int unsigned CntW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SAMPLE_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tick_q;

    always_comb begin
        cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk10m) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_q == CntMax);
        end
    end

    assign clk_sampling = tick_q;

endmodule

// File: rtl/dl_frame_streamer.sv
// TDC readout streamer: snapshots the delayline words on each sample tick and
// sends them as a framed byte stream (sync, seq, payload LSB-first, XOR checksum).
//   clk10m, rst   : clock and synchronous active-high reset
//   snap_data     : NCH*DATASIZE captured words, channel c at [c*DATASIZE +: DATASIZE]
//   clk_sampling  : sample tick pulse
//   tx            : UART byte handshake (master side)
//   busy          : frame in flight
//   seq           : sequence number of the current or next frame
//   overrun_cnt   : saturating count of ticks dropped while busy
module dl_frame_streamer
    import dl_pkg::*;
#(
    parameter int unsigned DATASIZE   = 128,
    parameter int unsigned NCH        = 1,
    parameter int unsigned SAMPLE_DIV = 333333,
    parameter logic [7:0]  SYNC_BYTE  = SyncByteDefault
) (
    input  logic                      clk10m,
    input  logic                      rst,
    input  logic [NCH*DATASIZE-1:0]   snap_data,
    output logic                      clk_sampling,
    dl_frame_streamer_if.master       tx,
    output logic                      busy,
    output logic [7:0]                seq,
    output logic [7:0]                overrun_cnt
);

    localparam int unsigned FLen   = frame_len(DATASIZE, NCH);
    localparam int unsigned NBytes = (NCH * DATASIZE) / 8;
    localparam int unsigned IdxW   = $clog2(FLen);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(FLen - 1);

    logic                    tick;
    logic [1:0]              state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [7:0]              csum_q, csum_d;
    logic [NCH*DATASIZE-1:0] snap_q, snap_d;
    logic [7:0]              tx_byte_q, tx_byte_d;
    logic                    tx_push_q, tx_push_d;
    logic                    busy_q, busy_d;
    logic [7:0]              seq_q, seq_d;
    logic [7:0]              ovr_q, ovr_d;

    logic [7:0] frame_bytes [FLen];
    logic [7:0] cur_byte;

    dl_tick_gen #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_tick_gen (
        .clk10m       (clk10m),
        .rst          (rst),
        .clk_sampling (tick)
    );

    assign frame_bytes[0]      = SYNC_BYTE;
    assign frame_bytes[1]      = seq_q;
    assign frame_bytes[FLen-1] = csum_q;

    for (genvar j = 0; j < NBytes; j++) begin : g_payload
        assign frame_bytes[j+2] = snap_q[8*j +: 8];
    end

    assign cur_byte = frame_bytes[idx_q];

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        snap_d    = snap_q;
        tx_byte_d = tx_byte_q;
        tx_push_d = 1'b0;
        busy_d    = busy_q;
        seq_d     = seq_q;
        ovr_d     = ovr_q;

        if (tick && (state_q != StIdle) && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end

        case (state_q)
            StIdle: begin
                if (tick) begin
                    snap_d  = snap_data;
                    csum_d  = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StPush;
                end
            end
            StPush: begin
                tx_byte_d = cur_byte;
                tx_push_d = 1'b1;
                if ((idx_q != '0) && (idx_q != IdxLast)) begin
                    csum_d = csum_q ^ cur_byte;
                end
                state_d = StWait;
            end
            StWait: begin
                // The cycle that shows tx_push still belongs to the push; a done
                // pulse coinciding with it cannot be for this byte.
                if (tx.tx_done && !tx_push_q) begin
                    if (idx_q == IdxLast) begin
                        seq_d   = seq_q + 8'd1;
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StPush;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk10m) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            csum_q    <= '0;
            snap_q    <= '0;
            tx_byte_q <= '0;
            tx_push_q <= 1'b0;
            busy_q    <= 1'b0;
            seq_q     <= '0;
            ovr_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            snap_q    <= snap_d;
            tx_byte_q <= tx_byte_d;
            tx_push_q <= tx_push_d;
            busy_q    <= busy_d;
            seq_q     <= seq_d;
            ovr_q     <= ovr_d;
        end
    end

    assign clk_sampling = tick;
    assign tx.tx_byte   = tx_byte_q;
    assign tx.tx_push   = tx_push_q;
    assign busy         = busy_q;
    assign seq          = seq_q;
    assign overrun_cnt  = ovr_q;

endmodule

// File: tb/tb_dl_frame_streamer.sv
// Self-checking bench for dl_frame_streamer (DATASIZE=16, NCH=2, SAMPLE_DIV=8).
module tb_dl_frame_streamer;

    localparam int unsigned DATASIZE   = 16;
    localparam int unsigned NCH        = 2;
    localparam int unsigned SAMPLE_DIV = 8;
    localparam int          FLEN       = 7;

    typedef struct packed {
        logic [15:0] ch0;
        logic [15:0] ch1;
        logic [55:0] bytes;   // byte 0 in the top octet
    } frame_vec_t;

    logic        clk10m = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] snap_data = '0;
    logic        clk_sampling;
    logic        busy;
    logic [7:0]  seq;
    logic [7:0]  overrun_cnt;

    dl_frame_streamer_if u_if ();

    dl_frame_streamer #(
        .DATASIZE   (DATASIZE),
        .NCH        (NCH),
        .SAMPLE_DIV (SAMPLE_DIV),
        .SYNC_BYTE  (8'hA5)
    ) dut (
        .clk10m       (clk10m),
        .rst          (rst),
        .snap_data    (snap_data),
        .clk_sampling (clk_sampling),
        .tx           (u_if),
        .busy         (busy),
        .seq          (seq),
        .overrun_cnt  (overrun_cnt)
    );

    always #50 clk10m = ~clk10m;

    int n_checks = 0;
    int n_pass   = 0;

    // UART model controls
    int resp_delay   = 5;
    bit resp_en      = 1'b1;
    bit spur_req     = 1'b0;
    bit spur_on_push = 1'b0;

    // Monitor state
    logic [7:0] pushq [$];
    int         pushc [$];
    int         cyc      = 0;
    int         tick_cyc = 0;
    int         exp_ovr  = 0;

    logic [7:0] fb [FLEN];
    int         fc [FLEN];

    // UART responder: tx_done resp_delay cycles after each push.
    initial begin
        int cnt;
        cnt = -1;
        u_if.tx_done = 1'b0;
        forever begin
            @(posedge clk10m);
            #1;
            u_if.tx_done = 1'b0;
            if (rst) begin
                cnt = -1;
            end else begin
                if (spur_req) begin
                    u_if.tx_done = 1'b1;
                    spur_req = 1'b0;
                end
                if (u_if.tx_push && resp_en) begin
                    cnt = resp_delay;
                    if (spur_on_push) u_if.tx_done = 1'b1;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        u_if.tx_done = 1'b1;
                        cnt = -1;
                    end
                end
            end
        end
    end

    // Push capture and overrun reference count.
    initial begin
        forever begin
            @(negedge clk10m);
            cyc++;
            if (rst) begin
                exp_ovr = 0;
            end else begin
                if (u_if.tx_push) begin
                    pushq.push_back(u_if.tx_byte);
                    pushc.push_back(cyc);
                end
                if (clk_sampling && !busy) tick_cyc = cyc;
                if (clk_sampling && busy && exp_ovr < 255) exp_ovr++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic bounded(input string name, input bit ok);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: timed out (got 0 expected 1)", name);
    endtask

    task automatic wait_bytes(input int n, input int budget, input string name);
        int t;
        t = 0;
        while (pushq.size() < n && t < budget) begin
            @(negedge clk10m);
            #2;
            t++;
        end
        if (pushq.size() < n) bounded(name, 1'b0);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < budget) begin
            @(negedge clk10m);
            #2;
            t++;
        end
        bounded(name, busy === 1'b0);
    endtask

    task automatic pop_frame();
        for (int k = 0; k < FLEN; k++) begin
            if (pushq.size() > 0) begin
                fb[k] = pushq.pop_front();
                fc[k] = pushc.pop_front();
            end else begin
                fb[k] = 8'hxx;
                fc[k] = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk10m);
        #2;
        rst = 1'b1;
        repeat (2) @(negedge clk10m);
        #2;
        rst = 1'b0;
        pushq.delete();
        pushc.delete();
    endtask

    frame_vec_t vecs [3];

    initial begin
        logic [55:0] exp_b;

        vecs[0] = {16'h1234, 16'h00FF, 56'hA5_00_34_12_FF_00_D9};
        vecs[1] = {16'hFFFF, 16'hFFFF, 56'hA5_01_FF_FF_FF_FF_01};
        vecs[2] = {16'hA55A, 16'h0F0F, 56'hA5_02_5A_A5_0F_0F_FD};

        // Reset state
        snap_data = {vecs[0].ch1, vecs[0].ch0};
        repeat (3) @(negedge clk10m);
        #2;
        check("rst clk_sampling", {31'd0, clk_sampling}, 0);
        check("rst tx_push", {31'd0, u_if.tx_push}, 0);
        check("rst tx_byte", {24'd0, u_if.tx_byte}, 0);
        check("rst busy", {31'd0, busy}, 0);
        check("rst seq", {24'd0, seq}, 0);
        check("rst overrun", {24'd0, overrun_cnt}, 0);
        rst = 1'b0;

        // Table frames, snap_data rewritten as soon as each frame has started
        for (int i = 0; i < 3; i++) begin
            wait_bytes(1, 200, $sformatf("frame%0d start", i));
            snap_data = (i < 2) ? {vecs[i+1].ch1, vecs[i+1].ch0} : 32'h0BAD_F00D;
            wait_bytes(FLEN, 400, $sformatf("frame%0d bytes", i));
            pop_frame();
            exp_b = vecs[i].bytes;
            for (int k = 0; k < FLEN; k++) begin
                check($sformatf("frame%0d byte%0d", i, k), {24'd0, fb[k]},
                      {24'd0, exp_b[(FLEN-1-k)*8 +: 8]});
            end
            check($sformatf("frame%0d tick-to-push", i), fc[0] - tick_cyc, 2);
            check($sformatf("frame%0d done-to-push", i), fc[1] - fc[0], resp_delay + 2);
            wait_idle(100, $sformatf("frame%0d idle", i));
            check($sformatf("frame%0d seq", i), {24'd0, seq}, i + 1);
            check($sformatf("frame%0d overrun", i), {24'd0, overrun_cnt}, exp_ovr);
        end

        // Reset mid-frame, after byte index 3 has been pushed
        wait_bytes(4, 400, "midframe bytes");
        rst = 1'b1;
        @(negedge clk10m);
        #2;
        check("midrst tx_push", {31'd0, u_if.tx_push}, 0);
        check("midrst busy", {31'd0, busy}, 0);
        check("midrst seq", {24'd0, seq}, 0);
        check("midrst overrun", {24'd0, overrun_cnt}, 0);
        rst = 1'b0;
        pushq.delete();
        pushc.delete();
        wait_bytes(FLEN, 400, "post-reset frame");
        pop_frame();
        exp_b = 56'hA5_00_0D_F0_AD_0B_5B;
        for (int k = 0; k < FLEN; k++) begin
            check($sformatf("postrst byte%0d", k), {24'd0, fb[k]},
                  {24'd0, exp_b[(FLEN-1-k)*8 +: 8]});
        end
        wait_idle(100, "postrst idle");

        // Overrun with a slow UART
        snap_data = {vecs[0].ch1, vecs[0].ch0};
        resp_delay = 20;
        do_reset();
        wait_bytes(FLEN, 600, "slow frame");
        wait_idle(100, "slow idle");
        check("slow push count", pushq.size(), FLEN);
        check("slow overrun", {24'd0, overrun_cnt}, exp_ovr);
        check("slow overrun nonzero", {31'd0, overrun_cnt > 8'd10}, 1);
        pop_frame();
        check("slow checksum", {24'd0, fb[6]}, 32'hD9);

        // Saturation: UART never answers, frame stalls
        resp_en = 1'b0;
        do_reset();
        wait_bytes(1, 200, "stall start");
        repeat (2500) @(negedge clk10m);
        #2;
        check("sat overrun", {24'd0, overrun_cnt}, 255);
        check("sat push count", pushq.size(), 1);
        check("sat busy", {31'd0, busy}, 1);
        resp_en = 1'b1;

        // Spurious tx_done in idle and coinciding with every push
        resp_delay = 5;
        do_reset();
        spur_req = 1'b1;
        spur_on_push = 1'b1;
        wait_bytes(FLEN, 400, "spur frame");
        wait_idle(100, "spur idle");
        check("spur push count", pushq.size(), FLEN);
        pop_frame();
        exp_b = vecs[0].bytes;
        for (int k = 0; k < FLEN; k++) begin
            check($sformatf("spur byte%0d", k), {24'd0, fb[k]},
                  {24'd0, exp_b[(FLEN-1-k)*8 +: 8]});
        end
        check("spur frame span", fc[FLEN-1] - fc[0], (FLEN - 1) * (resp_delay + 2));
        spur_on_push = 1'b0;

        // Sequence wrap across 257 frames
        resp_delay = 1;
        do_reset();
        for (int f = 0; f < 257; f++) begin
            wait_bytes(FLEN, 200, $sformatf("wrap frame%0d", f));
            pop_frame();
            check($sformatf("wrap seq byte f%0d", f), {24'd0, fb[1]}, f % 256);
        end
        wait_idle(100, "wrap idle");
        check("wrap seq out", {24'd0, seq}, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dl_frame_streamer.md
Name: dl_frame_streamer

Overview:
- Next-generation TDC readout streamer for the delayline platform.
- Generates a periodic sample tick and snapshots NCH captured delayline words of DATASIZE bits each.
- Serialises the snapshot into a framed byte stream: sync byte, sequence number, payload (channel 0 first, LSB byte first), XOR checksum.
- Drives an external UART TX through a push/done byte handshake and counts sample ticks dropped while a frame is in flight.

Parameters:
- DATASIZE, 128, bits per channel snapshot; must be a multiple of 8.
- NCH, 1, number of delayline channels; must be ≥1.
- SAMPLE_DIV, 333333, clk10m cycles per sample tick (10 MHz / 30 Hz); must be ≥2.
- SYNC_BYTE, 8'hA5, first byte of every frame.

Ports:
- clk10m  input  1  10 MHz system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- snap_data  input  NCH*DATASIZE  captured delayline words; channel c occupies bits [c*DATASIZE +: DATASIZE]; already synchronous to clk10m.
- clk_sampling  output  1  one-cycle sample tick pulse.
- tx_byte  output  8  byte presented to the UART.
- tx_push  output  1  one-cycle request to send tx_byte.
- tx_done  input  1  one-cycle pulse from the UART when the byte has finished.
- busy  output  1  high while a frame is being sent.
- seq  output  8  sequence number of the current or next frame.
- overrun_cnt  output  8  saturating count of dropped ticks.

Behaviour:
- Reset: while rst=1 on a clock edge, all of the following clear to 0: divider, clk_sampling, tx_byte, tx_push, busy, seq, overrun_cnt. State goes to IDLE, the byte index clears, and the snapshot register clears. Reset asserted mid-frame aborts the frame immediately; no further push is issued.
- Divider: counts 0..SAMPLE_DIV-1 and wraps. clk_sampling=1 for exactly the cycle after the count equals SAMPLE_DIV-1 (registered), giving period SAMPLE_DIV.
- Frame length: FLEN = 3 + NCH*DATASIZE/8 bytes. Byte index k runs 0..FLEN-1:
  - k=0: SYNC_BYTE.
  - k=1: seq.
  - k=2..FLEN-2: payload byte (k-2) of the snapshot; byte j is snap bits [8j+7:8j].
  - k=FLEN-1: XOR of bytes 1..FLEN-2. The sync byte is excluded from the checksum.
- States:
  - IDLE: busy=0. If clk_sampling=1, latch snap_data into the snapshot register, clear the checksum and index, set busy=1, go to PUSH.
  - PUSH: drive tx_byte with byte k, pulse tx_push=1 for one cycle, go to WAIT. Fold byte k into the checksum when 1≤k≤FLEN-2.
  - WAIT: tx_push=0; tx_byte is held stable. On tx_done=1:
    - if k=FLEN-1, increment seq (8-bit wrap 255→0), clear busy, go to IDLE;
    - otherwise increment k and go to PUSH.
  - tx_done is ignored in IDLE and PUSH.
- Latency: tick to first tx_push is 2 cycles (tick cycle → IDLE latch → PUSH). tx_done to the next tx_push is 2 cycles.
- Overrun: a tick in any state other than IDLE is dropped and overrun_cnt increments, saturating at 255. This includes a tick in the same cycle as the final tx_done. The frame in progress is unaffected; the snapshot register is not modified mid-frame.
- snap_data changes during a frame have no effect on the frame.

Decomposition:
- Package dl_pkg holds:
  - the state enum (IDLE=2'b00, PUSH=2'b01, WAIT=2'b11, plus spare 2'b10 which recovers to IDLE);
  - the SYNC_BYTE default;
  - the FLEN helper function.
- One sub-module, dl_tick_gen: the SAMPLE_DIV divider producing clk_sampling, with clk10m/rst ports and a SAMPLE_DIV parameter.
- Byte selection: an indexed array of bytes generated by a generate loop. Do not use a variable part-select.

Test Plan:
- Basic frame. DATASIZE=16, NCH=2, SAMPLE_DIV=8; ch0=16'h1234, ch1=16'h00FF; bench UART answers tx_done 5 cycles after each push.
  - Required: 6 pushes with bytes A5,00,34,12,FF,00, then checksum D9.
  - After the frame: seq=1, busy=0.
- Back-to-back frames. Same setup, snap_data changed to 16'hFFFF/16'hFFFF after the first tick.
  - Required: second frame A5,01,FF,FF,FF,FF,checksum 01.
  - snap_data changes during either frame do not alter its bytes.
- Overrun. SAMPLE_DIV=8, tx_done delay 20 cycles.
  - Required: overrun_cnt increments on every tick during a frame and no extra pushes occur.
  - Force 300 dropped ticks: overrun_cnt holds at 255.
- Spurious tx_done. Pulse tx_done while in IDLE and in the same cycle as tx_push.
  - Required: no index advance and no extra byte.
- Reset mid-frame. Assert rst for 1 cycle after byte 3 is pushed.
  - Required: next edge gives tx_push=0, busy=0, seq=0, overrun_cnt=0.
  - The next frame starts with A5,00.
- Sequence wrap. Run 256 frames.
  - Required: the 257th frame carries seq byte 00.
